// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity modes, receiver FSM states,
// oversampling ratio and the parity helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Parity bit the transmitter should have sent for a character.
  // Bits above the character length must already be zero.
  function automatic logic expected_parity(input logic [7:0] data, input parity_t mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Receive FIFO with first-word-fall-through head. A write into a full FIFO
// is accepted only when a pop happens in the same cycle; pops of an empty
// FIFO are ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             wr_ok;
  logic             rd_ok;

  assign rd_valid = (count_reg != '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign count    = count_reg;
  assign rd_ok    = rd_en & rd_valid;
  assign wr_ok    = wr_en & (~full | rd_en);
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

  // Storage array: written only when the write is accepted.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Occupancy update: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding a receive FIFO, with sticky
// framing / parity / overrun flags and a level interrupt.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PARITY_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16,
  parameter int      DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          rx_enable,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic                          err_clr,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          irq
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] HALF_TICK = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  logic                 sync1_reg, sync2_reg, prev_reg;
  logic                 start_edge;
  logic [DIV_WIDTH-1:0] div_val_reg, div_cnt_reg;
  logic                 tick;
  rx_state_t            state_reg, state_next;
  logic [3:0]           tick_cnt_reg, tick_cnt_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [7:0]           shift_reg, shift_next;
  logic                 wr_reg, wr_next;
  logic                 par_err_set, frame_err_set, overrun_set;
  logic                 fifo_full;
  logic [DATA_BITS-1:0] fifo_rd_data;

  // Two-flop resynchroniser plus the previous value for edge detection;
  // all idle high so reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign start_edge = prev_reg & ~sync2_reg & rx_enable & (state_reg == IDLE);

  // Baud divider: latches the divisor at start detection and emits one
  // oversample tick every div+1 clocks while a frame is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_val_reg <= '0;
      div_cnt_reg <= '0;
    end else if (start_edge) begin
      div_val_reg <= baud_div;
      div_cnt_reg <= '0;
    end else if (state_reg == IDLE || div_cnt_reg == div_val_reg) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign tick = (state_reg != IDLE) && (div_cnt_reg == div_val_reg);

  // Receiver FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      wr_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      wr_reg       <= wr_next;
    end
  end

  // Next-state logic: start-bit qualification at mid-bit, then one sample
  // every 16 ticks for data, parity and stop bits.
  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    wr_next       = 1'b0;
    par_err_set   = 1'b0;
    frame_err_set = 1'b0;
    if (state_reg != IDLE && !rx_enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            state_next    = START;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            shift_next    = '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_reg == HALF_TICK) begin
              tick_cnt_next = '0;
              state_next    = sync2_reg ? IDLE : DATA;
            end else begin
              tick_cnt_next = tick_cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_reg == LAST_TICK) begin
              tick_cnt_next = '0;
              shift_next[bit_cnt_reg[2:0]] = sync2_reg;
              if (bit_cnt_reg == LAST_DATA) begin
                bit_cnt_next = '0;
                state_next   = (PARITY == PARITY_NONE) ? STOP : PAR;
              end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end else begin
              tick_cnt_next = tick_cnt_reg + 1'b1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            if (tick_cnt_reg == LAST_TICK) begin
              tick_cnt_next = '0;
              par_err_set   = (sync2_reg != expected_parity(shift_reg, PARITY));
              state_next    = STOP;
            end else begin
              tick_cnt_next = tick_cnt_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt_reg == LAST_TICK) begin
              tick_cnt_next = '0;
              if (!sync2_reg) begin
                frame_err_set = 1'b1;
                state_next    = IDLE;
              end else if (bit_cnt_reg == LAST_STOP) begin
                wr_next    = 1'b1;
                state_next = IDLE;
              end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
              end
            end else begin
              tick_cnt_next = tick_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign overrun_set = wr_reg & fifo_full & ~rd_en;

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (err_clr) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (frame_err_set) frame_err  <= 1'b1;
      if (par_err_set)   parity_err <= 1'b1;
      if (overrun_set)   overrun    <= 1'b1;
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_reg),
    .wr_data  (shift_reg[DATA_BITS-1:0]),
    .rd_en    (rd_en),
    .rd_data  (fifo_rd_data),
    .rd_valid (rd_valid),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  // Zero-extend the character to the 8-bit read port.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rd_data
    if (gi < DATA_BITS) begin : g_bit
      assign rd_data[gi] = fifo_rd_data[gi];
    end else begin : g_pad
      assign rd_data[gi] = 1'b0;
    end
  end

  assign irq = rd_valid | frame_err | parity_err | overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an 8N1 / depth-16 receiver (a) and a 7E1 / depth-4
// receiver (b), both at baud_div=3 (64 clocks per bit).
module tb_uart_rx_fifo import uart_pkg::*; ();

  localparam int BIT_CLKS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_enable;
  logic        rxd_a, rxd_b;
  logic        rd_en_a, rd_en_b;
  logic        err_clr_a, err_clr_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic [4:0]  fifo_count_a;
  logic [2:0]  fifo_count_b;
  logic        frame_err_a, parity_err_a, overrun_a, irq_a;
  logic        frame_err_b, parity_err_b, overrun_b, irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut_a (
    .clk (clk), .rst (rst), .baud_div (baud_div), .rx_enable (rx_enable),
    .rxd (rxd_a), .rd_en (rd_en_a), .rd_data (rd_data_a), .rd_valid (rd_valid_a),
    .fifo_count (fifo_count_a), .err_clr (err_clr_a), .frame_err (frame_err_a),
    .parity_err (parity_err_a), .overrun (overrun_a), .irq (irq_a)
  );

  uart_rx_fifo #(
    .DATA_BITS (7), .PARITY (PARITY_EVEN), .FIFO_DEPTH (4)
  ) dut_b (
    .clk (clk), .rst (rst), .baud_div (baud_div), .rx_enable (rx_enable),
    .rxd (rxd_b), .rd_en (rd_en_b), .rd_data (rd_data_b), .rd_valid (rd_valid_b),
    .fifo_count (fifo_count_b), .err_clr (err_clr_b), .frame_err (frame_err_b),
    .parity_err (parity_err_b), .overrun (overrun_b), .irq (irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Drive a 10-bit frame LSB first, one bit per BIT_CLKS, then idle.
  task automatic send_frame(input bit to_b, input logic [9:0] frame);
    for (int i = 0; i < 10; i++) begin
      if (to_b) rxd_b = frame[i];
      else      rxd_a = frame[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] data, input logic stop);
    send_frame(1'b0, {stop, data, 1'b0});
  endtask

  task automatic send_b(input logic [6:0] data, input logic par);
    send_frame(1'b1, {1'b1, par, data, 1'b0});
  endtask

  task automatic pop(input bit to_b);
    if (to_b) rd_en_b = 1'b1; else rd_en_a = 1'b1;
    @(negedge clk);
    rd_en_a = 1'b0;
    rd_en_b = 1'b0;
  endtask

  task automatic clear_b();
    err_clr_b = 1'b1;
    @(negedge clk);
    err_clr_b = 1'b0;
  endtask

  initial begin
    logic [6:0] chars_b [5];
    chars_b[0] = 7'h11; chars_b[1] = 7'h22; chars_b[2] = 7'h33;
    chars_b[3] = 7'h44; chars_b[4] = 7'h7F;

    rst = 1'b1; baud_div = 16'd3; rx_enable = 1'b1;
    rxd_a = 1'b1; rxd_b = 1'b1;
    rd_en_a = 1'b0; rd_en_b = 1'b0; err_clr_a = 1'b0; err_clr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rd_valid_a", 32'(rd_valid_a), 32'h0);
    check("reset count_a", 32'(fifo_count_a), 32'h0);
    check("reset irq_a", 32'(irq_a), 32'h0);
    check("reset irq_b", 32'(irq_b), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 character 0xA5
    send_a(8'hA5, 1'b1);
    check("a5 rd_data", 32'(rd_data_a), 32'hA5);
    check("a5 rd_valid", 32'(rd_valid_a), 32'h1);
    check("a5 count", 32'(fifo_count_a), 32'h1);
    check("a5 errors", 32'({frame_err_a, parity_err_a, overrun_a}), 32'h0);
    check("a5 irq", 32'(irq_a), 32'h1);

    // 7E1 with wrong parity: 0x55 has four ones, correct even parity is 0
    send_b(7'h55, 1'b1);
    check("par rd_data", 32'(rd_data_b), 32'h55);
    check("par parity_err", 32'(parity_err_b), 32'h1);
    check("par irq", 32'(irq_b), 32'h1);
    clear_b();
    check("par cleared", 32'(parity_err_b), 32'h0);
    pop(1'b1);
    check("par popped count", 32'(fifo_count_b), 32'h0);
    check("par popped irq", 32'(irq_b), 32'h0);

    // Depth-4 overrun: five correct-parity characters, no reads
    for (int i = 0; i < 5; i++) send_b(chars_b[i], ^chars_b[i]);
    check("ovr count", 32'(fifo_count_b), 32'h4);
    check("ovr overrun", 32'(overrun_b), 32'h1);
    check("ovr parity_err", 32'(parity_err_b), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr head %0d", i), 32'(rd_data_b), 32'(chars_b[i]));
      pop(1'b1);
    end
    check("ovr drained valid", 32'(rd_valid_b), 32'h0);
    check("ovr irq sticky", 32'(irq_b), 32'h1);
    clear_b();
    check("ovr cleared irq", 32'(irq_b), 32'h0);

    // Bad stop bit on receiver a
    send_a(8'h12, 1'b0);
    check("frm frame_err", 32'(frame_err_a), 32'h1);
    check("frm count", 32'(fifo_count_a), 32'h1);
    check("frm head", 32'(rd_data_a), 32'hA5);

    // False start: line low for 4 ticks only
    rxd_a = 1'b0;
    repeat (16) @(negedge clk);
    rxd_a = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("false count", 32'(fifo_count_a), 32'h1);

    // Reset mid-DATA
    rxd_a = 1'b0;
    repeat (BIT_CLKS + 32) @(negedge clk);
    rst = 1'b1;
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst rd_valid", 32'(rd_valid_a), 32'h0);
    check("rst count", 32'(fifo_count_a), 32'h0);
    check("rst rd_data", 32'(rd_data_a), 32'h0);
    check("rst errors", 32'({frame_err_a, parity_err_a, overrun_a}), 32'h0);
    check("rst irq", 32'(irq_a), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_a(8'h3C, 1'b1);
    check("3c rd_data", 32'(rd_data_a), 32'h3C);
    check("3c count", 32'(fifo_count_a), 32'h1);
    check("3c errors", 32'({frame_err_a, parity_err_a, overrun_a}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
